// File: rtl/lv_bist_ctrl_if.sv
// Handshake bundle between the LV BIST sequencer and its surroundings
// (analog BIST stage, loopback path and LV top).
interface lv_bist_ctrl_if;
  logic       i_bist_start;
  logic       i_lbist_en;
  logic       i_lv_abist_rult;
  logic [7:0] i_lbist_rdbk;
  logic       o_bist_en;
  logic [7:0] o_lbist_pat;
  logic       o_lbist_vld;
  logic       o_bist_busy;
  logic       o_bist_done;
  logic       o_bist_pass;
  logic       o_abist_fail;
  logic       o_lbist_fail;
  logic       o_bist_tmo;

  modport master (
    output i_bist_start, i_lbist_en, i_lv_abist_rult, i_lbist_rdbk,
    input  o_bist_en, o_lbist_pat, o_lbist_vld, o_bist_busy, o_bist_done,
    input  o_bist_pass, o_abist_fail, o_lbist_fail, o_bist_tmo
  );

  modport slave (
    input  i_bist_start, i_lbist_en, i_lv_abist_rult, i_lbist_rdbk,
    output o_bist_en, o_lbist_pat, o_lbist_vld, o_bist_busy, o_bist_done,
    output o_bist_pass, o_abist_fail, o_lbist_fail, o_bist_tmo
  );
endinterface

// File: rtl/lv_bist_ctrl.sv
// LV-domain BIST sequencer: enables the analog BIST, supervises its handoff with a timeout,
// runs a 4-pattern loopback logic BIST and reports pass/fail with sticky detail flags.
module lv_bist_ctrl #(
  parameter int unsigned CLK_M       = 48,
  parameter int unsigned BIST_TMO_US = 100
) (
  input logic           i_clk,
  input logic           i_rst_n,
  lv_bist_ctrl_if.slave bus
);

  localparam int unsigned     TmoCyc  = BIST_TMO_US * CLK_M;
  localparam int unsigned     TmoW    = $clog2(TmoCyc + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TmoCyc - 1);

  typedef enum logic [1:0] {StIdle, StAbist, StLbist, StDone} state_e;

  state_e          state_q, state_d;
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [2:0]      lb_cnt_q, lb_cnt_d;
  logic [2:0]      lb_prev_idx;
  logic            abist_fail_q, abist_fail_d;
  logic            lbist_fail_q, lbist_fail_d;
  logic            tmo_q, tmo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            vld_q, vld_d;
  logic [7:0]      pat_q, pat_d;

  function automatic logic [7:0] lbist_pattern(input logic [2:0] idx);
    case (idx)
      3'd0:    lbist_pattern = 8'h55;
      3'd1:    lbist_pattern = 8'hAA;
      3'd2:    lbist_pattern = 8'h00;
      3'd3:    lbist_pattern = 8'hFF;
      default: lbist_pattern = 8'h00;
    endcase
  endfunction

  // Readback in this cycle reflects the pattern driven one cycle earlier.
  assign lb_prev_idx = lb_cnt_q - 3'd1;

  always_comb begin
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    lb_cnt_d     = lb_cnt_q;
    abist_fail_d = abist_fail_q;
    lbist_fail_d = lbist_fail_q;
    tmo_d        = tmo_q;

    case (state_q)
      StIdle: begin
        if (bus.i_bist_start) begin
          state_d   = StAbist;
          tmo_cnt_d = '0;
        end
      end
      StAbist: begin
        // Handoff takes priority over a coincident timeout.
        if (bus.i_lbist_en) begin
          abist_fail_d = ~bus.i_lv_abist_rult;
          lb_cnt_d     = '0;
          state_d      = StLbist;
        end else if (tmo_cnt_q == TmoLast) begin
          tmo_d        = 1'b1;
          abist_fail_d = 1'b1;
          state_d      = StDone;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TmoW'(1);
        end
      end
      StLbist: begin
        if (!bus.i_lbist_en) begin
          lbist_fail_d = 1'b1;
          state_d      = StDone;
        end else begin
          if ((lb_cnt_q != 3'd0) && (bus.i_lbist_rdbk != lbist_pattern(lb_prev_idx))) begin
            lbist_fail_d = 1'b1;
          end
          if (lb_cnt_q == 3'd4) begin
            state_d = StDone;
          end else begin
            lb_cnt_d = lb_cnt_q + 3'd1;
          end
        end
      end
      StDone: begin
        if (bus.i_bist_start) begin
          abist_fail_d = 1'b0;
          lbist_fail_d = 1'b0;
          tmo_d        = 1'b0;
          tmo_cnt_d    = '0;
          state_d      = StAbist;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    busy_d = (state_d == StAbist) || (state_d == StLbist);
    done_d = (state_d == StDone);
    pass_d = done_d && !(abist_fail_d || lbist_fail_d || tmo_d);
    vld_d  = (state_d == StLbist) && (lb_cnt_d < 3'd4);
    pat_d  = vld_d ? lbist_pattern(lb_cnt_d) : 8'h00;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      tmo_cnt_q    <= '0;
      lb_cnt_q     <= '0;
      abist_fail_q <= 1'b0;
      lbist_fail_q <= 1'b0;
      tmo_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      vld_q        <= 1'b0;
      pat_q        <= 8'h00;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      lb_cnt_q     <= lb_cnt_d;
      abist_fail_q <= abist_fail_d;
      lbist_fail_q <= lbist_fail_d;
      tmo_q        <= tmo_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      vld_q        <= vld_d;
      pat_q        <= pat_d;
    end
  end

  assign bus.o_bist_en    = busy_q;
  assign bus.o_bist_busy  = busy_q;
  assign bus.o_bist_done  = done_q;
  assign bus.o_bist_pass  = pass_q;
  assign bus.o_abist_fail = abist_fail_q;
  assign bus.o_lbist_fail = lbist_fail_q;
  assign bus.o_bist_tmo   = tmo_q;
  assign bus.o_lbist_vld  = vld_q;
  assign bus.o_lbist_pat  = pat_q;

endmodule

// File: doc/lv_bist_ctrl.md
# lv_bist_ctrl

LV-domain built-in self-test sequencer sitting directly upstream of the analog BIST stage. On a start pulse it enables the analog BIST and waits for that stage's logic-BIST handoff while supervising a timeout. It then runs a short pattern-loopback logic BIST, latches the analog and logic verdicts, and reports a single pass/fail with sticky detail flags to the LV top.

## Interface
- CLK_M, 48, i_clk cycles per microsecond
- BIST_TMO_US, 100, analog-phase timeout in us; TMO_CYC = BIST_TMO_US*CLK_M; must exceed 70*CLK_M+4
- i_clk  input  1  system clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_bist_start  input  1  single-cycle start request
- i_lbist_en  input  1  analog BIST finished its 70 us window; logic BIST may run
- i_lv_abist_rult  input  1  analog BIST result, 1 = pass
- i_lbist_rdbk  input  8  registered loopback of o_lbist_pat (one-cycle path)
- o_bist_en  output  1  enable to the analog BIST stage
- o_lbist_pat  output  8  logic-BIST test pattern
- o_lbist_vld  output  1  o_lbist_pat valid
- o_bist_busy  output  1  sequence running (ABIST or LBIST)
- o_bist_done  output  1  results valid
- o_bist_pass  output  1  overall pass
- o_abist_fail  output  1  sticky: analog result was fail
- o_lbist_fail  output  1  sticky: loopback mismatch or handoff lost
- o_bist_tmo  output  1  sticky: i_lbist_en not seen within TMO_CYC

## Operation
- States: IDLE, ABIST, LBIST, DONE. Reset -> IDLE.
- IDLE: i_bist_start=1 -> ABIST; clear the tmo counter.
- ABIST: o_bist_en=1; the tmo counter increments each cycle.
  - i_lbist_en=1 -> latch o_abist_fail = ~i_lv_abist_rult; go to LBIST; lb_cnt=0.
  - Else counter == TMO_CYC-1 -> o_bist_tmo=1, o_abist_fail=1; go to DONE.
  - i_lbist_en and timeout in the same cycle: i_lbist_en wins, no tmo.
- LBIST: o_bist_en stays 1; lb_cnt counts 0..4.
  - lb_cnt 0..3: o_lbist_vld=1; o_lbist_pat = 8'h55, 8'hAA, 8'h00, 8'hFF respectively.
  - lb_cnt 1..4: compare i_lbist_rdbk to the pattern driven at lb_cnt-1; a mismatch sets o_lbist_fail.
  - lb_cnt==4 -> DONE.
  - i_lbist_en=0 in any LBIST cycle -> o_lbist_fail=1; go to DONE immediately (abort).
- DONE: o_bist_done=1; o_bist_en=0.
  - o_bist_pass = ~(o_abist_fail | o_lbist_fail | o_bist_tmo).
  - i_bist_start=1 -> clear all three fail flags; go to ABIST.
- i_bist_start is ignored in ABIST and LBIST.
- o_lbist_pat = 8'h00 whenever o_lbist_vld=0.
- All outputs are registered.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset mid-sequence aborts at once; all flags clear.
- Start latency: i_bist_start sampled at edge N gives o_bist_en=1 and o_bist_busy=1 from cycle N+1.
- o_bist_en is low for at least one cycle between runs (DONE always spans at least one cycle), so the analog stage counter restarts from 0.
- Analog handoff: with the downstream stage, i_lbist_en rises about 70*CLK_M+2 cycles after o_bist_en rises. The LBIST state is entered on the following edge.
- LBIST duration: exactly 5 cycles when not aborted. o_lbist_vld is high for 4 cycles.
- o_bist_done rises on the edge that enters DONE and falls on the edge that leaves DONE. Flags are stable while done=1.
- Timeout: counter width $clog2(TMO_CYC+1), unsigned, no wrap (the state exits at TMO_CYC-1). Timeout path duration: o_bist_en high for exactly TMO_CYC cycles.
- o_bist_busy = (state==ABIST)|(state==LBIST); o_bist_busy and o_bist_done are never both 1.

## Test plan
- Nominal pass (CLK_M=1, BIST_TMO_US=100):
  - Stimulus: start pulse; i_lbist_en rises 72 cycles later with rult=1; rdbk is a 1-cycle delay of pat.
  - Response: pattern sequence 55,AA,00,FF; done 5 cycles after LBIST entry; pass=1; all fail flags 0.
- Analog fail: as nominal with i_lv_abist_rult=0 at handoff -> abist_fail=1, lbist_fail=0, pass=0.
- Timeout: start pulse, i_lbist_en held 0 -> o_bist_en high exactly 100 cycles; then done=1, tmo=1, abist_fail=1, pass=0.
- Loopback error: force rdbk=8'h00 during the second compare (expected AA) -> lbist_fail=1, pass=0, done still on the 5th LBIST cycle.
- Handoff lost: drop i_lbist_en in LBIST cycle 2 -> DONE next edge, lbist_fail=1; restart from DONE clears the flags, and a clean rerun gives pass=1.
- Corner cases:
  - i_lbist_en rises in the same cycle the counter reaches 99 -> LBIST entered, tmo=0.
  - Start pulses during ABIST are ignored.
  - i_rst_n asserted in LBIST -> all outputs 0 at once.
